matmult_ctrl: RTL and testbench

MATMULT_CTRL -- requirements
Module: matmult_ctrl

---
 rtl/matmult_pkg.sv | 23 ++
 rtl/matmult_idx_cnt.sv | 38 +++
 rtl/matmult_ctrl.sv | 119 +++++++++++
 tb/tb_matmult_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmult_pkg.sv
// Shared parameters, state encoding and index-width helper for the matrix-multiply controller.
package matmult_pkg;

  localparam int N          = 4;
  localparam int DATA_WIDTH = 32;
  localparam int IDX_W      = $clog2(N);
  localparam int TIMEOUT    = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE,
    ERROR
  } state_t;

  // Keeps index ports at least one bit wide when N is 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmult_idx_cnt.sv
// Row-major (row, col) walker over an NxN result; last flags the final element.
module matmult_idx_cnt
  import matmult_pkg::*;
#(
  parameter int N  = matmult_pkg::N,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last
);

  localparam logic [IW-1:0] MAX = IW'(N - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == MAX) begin
        col <= '0;
        row <= (row == MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == MAX) && (col == MAX);

endmodule

// File: rtl/matmult_ctrl.sv
// Sequences an external dot-product unit over all NxN result elements and emits row-major writes.
module matmult_ctrl
  import matmult_pkg::*;
#(
  parameter int N          = matmult_pkg::N,
  parameter int DATA_WIDTH = matmult_pkg::DATA_WIDTH,
  parameter int TIMEOUT    = matmult_pkg::TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  product_done,
  input  logic [DATA_WIDTH-1:0] sum,
  output logic                  enable_product,
  output logic [idx_w(N)-1:0]   a_row,
  output logic [idx_w(N)-1:0]   b_col,
  output logic                  res_we,
  output logic [idx_w(N)-1:0]   res_row,
  output logic [idx_w(N)-1:0]   res_col,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int IW = idx_w(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic          clr_idx, adv_idx, last;

  matmult_idx_cnt #(.N(N), .IW(IW)) u_idx (
    .clk     (clk),
    .reset   (reset),
    .clear   (clr_idx),
    .advance (adv_idx),
    .row     (a_row),
    .col     (b_col),
    .last    (last)
  );

  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
  assign res_row     = a_row;
  assign res_col     = b_col;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    enable_product = 1'b0;
    res_we         = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    clr_idx        = 1'b0;
    adv_idx        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          clr_idx   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        enable_product = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        // A result arriving on the timeout cycle is still accepted.
        enable_product = 1'b1;
        if (product_done)     state_nxt = WRITE;
        else if (timeout_hit) state_nxt = ERROR;
      end
      WRITE: begin
        res_we = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end else begin
          adv_idx   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERROR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      res_data <= '0;
      error    <= 1'b0;
    end else begin
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT && !timeout_hit)
        wait_cnt <= wait_cnt + 1'b1;

      if (state == WAIT && product_done)
        res_data <= sum;

      // Sticky until the next accepted start.
      if (state == IDLE && start)
        error <= 1'b0;
      else if (state == WAIT && !product_done && timeout_hit)
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matmult_ctrl.sv
// Randomized bench: behavioural dot-product unit plus a row-major reference of C = A x B.
module tb_matmult_ctrl;
  import matmult_pkg::*;

  localparam int NN = matmult_pkg::N;
  localparam int DW = matmult_pkg::DATA_WIDTH;
  localparam int TO = matmult_pkg::TIMEOUT;
  localparam int IW = idx_w(NN);

  logic          clk = 1'b0;
  logic          reset, start, product_done;
  logic [DW-1:0] sum;
  logic          enable_product, res_we, busy, done, error;
  logic [IW-1:0] a_row, b_col, res_row, res_col;
  logic [DW-1:0] res_data;

  matmult_ctrl #(.N(NN), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .product_done   (product_done),
    .sum            (sum),
    .enable_product (enable_product),
    .a_row          (a_row),
    .b_col          (b_col),
    .res_we         (res_we),
    .res_row        (res_row),
    .res_col        (res_col),
    .res_data       (res_data),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  int                   A [NN][NN];
  int                   B [NN][NN];
  logic signed [DW-1:0] C [NN][NN];
  logic signed [DW-1:0] got_c [NN][NN];

  task automatic ref_compute;
    for (int r = 0; r < NN; r++)
      for (int c = 0; c < NN; c++) begin
        longint acc = 0;
        for (int k = 0; k < NN; k++) acc += longint'(A[r][k]) * longint'(B[k][c]);
        C[r][c] = acc[DW-1:0];
      end
  endtask

  task automatic load_seq;
    for (int r = 0; r < NN; r++)
      for (int c = 0; c < NN; c++) begin
        A[r][c] = r * NN + c;
        B[r][c] = r * NN + c;
      end
  endtask

  task automatic load_rand;
    for (int r = 0; r < NN; r++)
      for (int c = 0; c < NN; c++) begin
        A[r][c] = int'($urandom_range(0, 1000)) - 500;
        B[r][c] = int'($urandom_range(0, 1000)) - 500;
      end
  endtask

  function automatic logic [DW-1:0] dot(input int r, input int c);
    longint acc = 0;
    for (int k = 0; k < NN; k++) acc += longint'(A[r][k]) * longint'(B[k][c]);
    return acc[DW-1:0];
  endfunction

  // Dot-product unit model: answers lat_cur WAIT cycles after the run request rises.
  bit model_on  = 1'b1;
  bit spur_on   = 1'b0;
  int lat_fixed = 1;
  int lat_cur   = 1;
  int en_cnt    = 0;

  always @(negedge clk) begin
    if (!enable_product || !model_on) begin
      en_cnt       = 0;
      product_done = spur_on && ($urandom_range(0, 2) == 0);
      sum          = DW'($urandom);
    end else begin
      en_cnt++;
      if (en_cnt == 1) begin
        lat_cur      = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
        product_done = spur_on && ($urandom_range(0, 1) == 1);
        sum          = DW'($urandom);
      end else if (en_cnt >= 1 + lat_cur) begin
        product_done = 1'b1;
        sum          = dot(int'(a_row), int'(b_col));
      end else begin
        product_done = 1'b0;
        sum          = DW'($urandom);
      end
    end
  end

  int wr_cnt   = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (res_we) begin
      if (wr_cnt < NN * NN) begin
        check("wr_row", res_row, wr_cnt / NN);
        check("wr_col", res_col, wr_cnt % NN);
        check("wr_data", $signed(res_data), C[wr_cnt / NN][wr_cnt % NN]);
        got_c[res_row][res_col] = res_data;
      end
      check("en_low_in_write", enable_product, 0);
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic do_run(input bit hold, input int budget, output int cyc, output bit ok, output int busy_low);
    wr_cnt   = 0;
    done_cnt = 0;
    busy_low = 0;
    ok       = 1'b0;
    cyc      = budget;
    start    = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (!hold) start = 1'b0;
      if (!busy) busy_low++;
      if (done || error) begin
        ok  = done;
        cyc = i + 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic post_run(input string tag, input bit ok, input int busy_low);
    check({tag, "_done_seen"}, ok, 1);
    check({tag, "_busy_gap"}, busy_low, 0);
    check({tag, "_writes"}, wr_cnt, NN * NN);
    check({tag, "_done_pulses"}, done_cnt, 1);
    tick;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_after"}, done, 0);
    repeat (6) tick;
    check({tag, "_no_restart"}, wr_cnt, NN * NN);
    check({tag, "_done_once"}, done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, busy_low, k;
    bit ok, found;

    reset = 1'b0;
    start = 1'b0;
    tick;
    tick;
    check("reset_outputs", {enable_product, a_row, b_col, res_we, res_row, res_col, res_data, busy, done, error}, 0);
    reset = 1'b1;
    tick;

    load_seq;
    ref_compute;
    lat_fixed = 1;
    spur_on   = 1'b0;
    do_run(1'b0, 400, cyc, ok, busy_low);
    check("seq_cycles", cyc, 3 * NN * NN + 1);
    check("seq_c00", got_c[0][0], 56);
    check("seq_c33", got_c[NN-1][NN-1], 506);
    post_run("seq", ok, busy_low);

    for (int r = 0; r < 3; r++) begin
      load_rand;
      ref_compute;
      lat_fixed = 0;
      spur_on   = 1'b1;
      do_run(r == 1, 600, cyc, ok, busy_low);
      post_run($sformatf("rand%0d", r), ok, busy_low);
    end

    model_on = 1'b0;
    spur_on  = 1'b0;
    wr_cnt   = 0;
    start    = 1'b1;
    tick;
    start = 1'b0;
    k     = 1;
    while (!error && k < TO + 10) begin
      tick;
      k++;
    end
    check("timeout_cycles", k, TO + 2);
    check("timeout_en_low", enable_product, 0);
    check("timeout_busy_in_err", busy, 1);
    tick;
    check("timeout_busy_drop", busy, 0);
    check("timeout_sticky", error, 1);
    check("timeout_no_we", wr_cnt, 0);

    model_on  = 1'b1;
    lat_fixed = 1;
    load_rand;
    ref_compute;
    wr_cnt   = 0;
    done_cnt = 0;
    start    = 1'b1;
    tick;
    start = 1'b0;
    check("error_cleared", error, 0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (enable_product && a_row == 1 && b_col == 2) found = 1'b1;
      else tick;
    end
    check("reach_elem_1_2", found, 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrun_reset_outputs", {enable_product, a_row, b_col, res_we, res_row, res_col, res_data, busy, done, error}, 0);
    k = wr_cnt;
    tick;
    tick;
    reset = 1'b1;
    repeat (6) tick;
    check("midrun_no_more_we", wr_cnt, k);
    check("midrun_no_done", done_cnt, 0);
    check("midrun_idle", busy, 0);

    do_run(1'b0, 600, cyc, ok, busy_low);
    post_run("restart", ok, busy_low);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
